// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit:
// operation encodings, FSM state encoding and the default datapath width.
package mips_pkg;

  localparam int MULDIV_WIDTH = 32;

  // Encoding of the op input: bit 0 selects divide, bit 1 selects signed.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling for the multiply/divide unit.
// Latch side: turns the raw operands into magnitudes and records their signs.
// Fix side: re-applies signs to the unsigned result of the iterative core.
//   multiply: the 2*WIDTH product is negated when the operand signs differ
//   divide:   quotient negated when signs differ, remainder takes a's sign
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic             sgn_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_mag,
  output logic             a_neg,
  output logic             b_neg,
  input  logic             sgn_fix,
  input  logic             is_div,
  input  logic             neg_a,
  input  logic             neg_b,
  input  logic [WIDTH-1:0] res_hi,
  input  logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic [2*WIDTH-1:0] prod_neg;

  // Operand magnitudes; a negative two's-complement value is negated.
  always_comb begin
    a_neg = sgn_in & a[WIDTH-1];
    b_neg = sgn_in & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  // Result sign correction; unsigned results pass straight through.
  always_comb begin
    prod_neg = ~{res_hi, res_lo} + 1'b1;
    fix_hi   = res_hi;
    fix_lo   = res_lo;
    if (sgn_fix) begin
      if (is_div) begin
        if (neg_a ^ neg_b) fix_lo = ~res_lo + 1'b1;
        if (neg_a)         fix_hi = ~res_hi + 1'b1;
      end else if (neg_a ^ neg_b) begin
        fix_hi = prod_neg[2*WIDTH-1:WIDTH];
        fix_lo = prod_neg[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit.
// Multiply is radix-2 shift-add, divide is restoring division; both spend
// WIDTH cycles in RUN then one cycle in FIX, where HI/LO are written and
// done pulses. Divide by zero skips RUN entirely.
// Build option: define MULDIV_SIGNED_EN to make MULT/DIV signed; without it
// op[1] is ignored and all four ops run unsigned.
//
// Handshake: start is a request that is taken only when the unit is idle
// (busy low); it is ignored otherwise and never queued. Completion is the
// one-cycle done pulse; hi/lo carry the new result from that cycle on and a
// new start may be presented in the done cycle itself.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic          busy,
  output logic          done,
  output logic          divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output muldiv_state_t dbg_state
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;   // product high half / partial remainder
  logic [WIDTH-1:0] q_q;     // multiplier (shifts out) / quotient (shifts in)
  logic [WIDTH-1:0] m_q;     // multiplicand / divisor magnitude
  logic             div_q, sgn_q, neg_a_q, neg_b_q, dz_q;

  logic             is_div_in, is_signed_in, b_zero, take;
  logic [WIDTH-1:0] a_mag, b_mag, fix_hi, fix_lo;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc;

  assign is_div_in = op[0];
`ifdef MULDIV_SIGNED_EN
  assign is_signed_in = op[1];
`else
  logic unused_op_sign;
  assign unused_op_sign = op[1];
  assign is_signed_in   = 1'b0;
`endif

  assign b_zero    = (b == '0);
  assign take      = (state_q == ST_IDLE) && start;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .sgn_in  (is_signed_in),
    .a       (a),
    .b       (b),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .a_neg   (a_neg),
    .b_neg   (b_neg),
    .sgn_fix (sgn_q),
    .is_div  (div_q),
    .neg_a   (neg_a_q),
    .neg_b   (neg_b_q),
    .res_hi  (acc_q),
    .res_lo  (q_q),
    .fix_hi  (fix_hi),
    .fix_lo  (fix_lo)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: divide by zero goes straight to FIX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (is_div_in && b_zero) ? ST_FIX : ST_RUN;
      ST_RUN:  if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One iteration step of each algorithm.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    div_shift = {acc_q, q_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m_q});
    // When div_ge holds the true difference is below m_q, so the low
    // WIDTH bits of the subtraction are exact.
    div_acc   = div_ge ? (div_shift[WIDTH-1:0] - m_q) : div_shift[WIDTH-1:0];
  end

  // Operand latch and iterative datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (take) begin
      cnt_q   <= '0;
      div_q   <= is_div_in;
      sgn_q   <= is_signed_in;
      neg_a_q <= a_neg;
      neg_b_q <= b_neg;
      dz_q    <= is_div_in && b_zero;
      m_q     <= b_mag;
      if (is_div_in && b_zero) begin
        // Divide by zero result is prepared here: hi = raw a, lo = all ones.
        acc_q <= a;
        q_q   <= '1;
      end else begin
        acc_q <= '0;
        q_q   <= a_mag;
      end
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      if (div_q) begin
        acc_q <= div_acc;
        q_q   <= {q_q[WIDTH-2:0], div_ge};
      end else begin
        acc_q <= mul_sum[WIDTH:1];
        q_q   <= {mul_sum[0], q_q[WIDTH-1:1]};
      end
    end
  end

  // HI/LO update and completion flags, all at FIX exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      done    <= (state_q == ST_FIX);
      divzero <= (state_q == ST_FIX) && dz_q;
      if (state_q == ST_FIX) begin
        if (dz_q) begin
          hi <= acc_q;
          lo <= q_q;
        end else begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
      end
    end
  end

endmodule
